fcmp_pipe: RTL and testbench

- Parametrised, pipelined floating-point compare unit for the FPU. Supersedes the single-op combinational fle path.
- Executes feq, flt, fle, fmin and fmax on IEEE-754-style operands of configurable width.
- Correct ±0 and NaN semantics; raises an invalid-operation flag.
- valid/ready handshake on input and output, a tag carried through, and full backpressure support.

---
 rtl/fcmp_pipe.sv | 196 +++++++++++++++++++
 tb/tb_fcmp_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fcmp_pipe.sv
// Pipelined IEEE-754-style compare unit: feq/flt/fle/fmin/fmax with NaN and signed-zero handling.
// Valid/ready on both sides; a stage advances when it is empty or the next stage advances.
module fcmp_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int PIPE  = 2,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [EXP_W+MAN_W:0]   in_x1,
    input  logic [EXP_W+MAN_W:0]   in_x2,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_y,
    output logic                   out_nv,
    output logic [TAG_W-1:0]       out_tag
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [2:0] OP_FEQ  = 3'd0;
    localparam logic [2:0] OP_FLT  = 3'd1;
    localparam logic [2:0] OP_FLE  = 3'd2;
    localparam logic [2:0] OP_FMIN = 3'd3;
    localparam logic [2:0] OP_FMAX = 3'd4;
    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     k1;
        logic [W-1:0]     k2;
        logic             sg1;
        logic             sg2;
        logic             nan1;
        logic             nan2;
        logic             snan1;
        logic             snan2;
        logic             zero1;
        logic             zero2;
    } pre_t;

    // Unsigned key whose ordering matches the numeric ordering; both zeros map to one key.
    function automatic logic [W-1:0] key_of(input logic [W-1:0] x, input logic zero);
        if (zero)
            return {1'b1, {(W-1){1'b0}}};
        else if (!x[W-1])
            return {1'b1, x[W-2:0]};
        else
            return ~x;
    endfunction

    // The key is invertible once the sign is known, so operands need not be carried.
    function automatic logic [W-1:0] operand_of(input logic [W-1:0] k, input logic sg,
                                                input logic zero);
        if (zero)
            return {sg, {(W-1){1'b0}}};
        else if (sg)
            return ~k;
        else
            return {1'b0, k[W-2:0]};
    endfunction

    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] m1, m2;
    pre_t             pre_d;
    pre_t             pre_s;
    logic             pre_v;
    logic             adv_o;

    assign e1 = in_x1[W-2:MAN_W];
    assign e2 = in_x2[W-2:MAN_W];
    assign m1 = in_x1[MAN_W-1:0];
    assign m2 = in_x2[MAN_W-1:0];

    always_comb begin
        pre_d       = '0;
        pre_d.op    = in_op;
        pre_d.tag   = in_tag;
        pre_d.sg1   = in_x1[W-1];
        pre_d.sg2   = in_x2[W-1];
        pre_d.nan1  = (&e1) && (|m1);
        pre_d.nan2  = (&e2) && (|m2);
        pre_d.snan1 = pre_d.nan1 && !m1[MAN_W-1];
        pre_d.snan2 = pre_d.nan2 && !m2[MAN_W-1];
        pre_d.zero1 = (e1 == '0) && (m1 == '0);
        pre_d.zero2 = (e2 == '0) && (m2 == '0);
        pre_d.k1    = key_of(in_x1, pre_d.zero1);
        pre_d.k2    = key_of(in_x2, pre_d.zero2);
    end

    logic         any_nan, any_snan, lt, eq, is_min;
    logic [W-1:0] x1_r, x2_r, y_d;
    logic         nv_d;

    assign any_nan  = pre_s.nan1 || pre_s.nan2;
    assign any_snan = pre_s.snan1 || pre_s.snan2;
    assign lt       = pre_s.k1 < pre_s.k2;
    assign eq       = pre_s.k1 == pre_s.k2;
    assign is_min   = pre_s.op == OP_FMIN;
    assign x1_r     = operand_of(pre_s.k1, pre_s.sg1, pre_s.zero1);
    assign x2_r     = operand_of(pre_s.k2, pre_s.sg2, pre_s.zero2);

    always_comb begin
        y_d  = '0;
        nv_d = 1'b0;
        case (pre_s.op)
            OP_FEQ: begin
                y_d[0] = !any_nan && eq;
                nv_d   = any_snan;
            end
            OP_FLT: begin
                y_d[0] = !any_nan && lt;
                nv_d   = any_nan;
            end
            OP_FLE: begin
                y_d[0] = !any_nan && (lt || eq);
                nv_d   = any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                nv_d = any_snan;
                if (pre_s.nan1 && pre_s.nan2)
                    y_d = CANON_NAN;
                else if (pre_s.nan1)
                    y_d = x2_r;
                else if (pre_s.nan2)
                    y_d = x1_r;
                else if (pre_s.zero1 && pre_s.zero2)
                    y_d = {is_min, {(W-1){1'b0}}};
                else if (is_min == lt)
                    y_d = x1_r;
                else
                    y_d = x2_r;
            end
            default: begin
                y_d  = '0;
                nv_d = 1'b0;
            end
        endcase
    end

    logic             vo_q;
    logic [W-1:0]     y_q;
    logic             nv_q;
    logic [TAG_W-1:0] tag_q;

    assign adv_o = !vo_q || out_ready;

    generate
        if (PIPE == 1) begin : g_p1
            assign pre_s    = pre_d;
            assign pre_v    = in_valid;
            assign in_ready = adv_o;
        end else begin : g_p2
            pre_t pre_q;
            logic v1_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    v1_q  <= 1'b0;
                    pre_q <= '0;
                end else if (!v1_q || adv_o) begin
                    v1_q <= in_valid;
                    if (in_valid)
                        pre_q <= pre_d;
                end
            end
            assign pre_s    = pre_q;
            assign pre_v    = v1_q;
            assign in_ready = !v1_q || adv_o;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vo_q  <= 1'b0;
            y_q   <= '0;
            nv_q  <= 1'b0;
            tag_q <= '0;
        end else if (adv_o) begin
            vo_q <= pre_v;
            if (pre_v) begin
                y_q   <= y_d;
                nv_q  <= nv_d;
                tag_q <= pre_s.tag;
            end
        end
    end

    assign out_valid = vo_q;
    assign out_y     = y_q;
    assign out_nv    = nv_q;
    assign out_tag   = tag_q;
endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe (W=32, PIPE=2): directed ops, backpressure and mid-flight reset,
// with a queue of expected {tag, nv, y} popped as results leave the unit.
module tb_fcmp_pipe;
    localparam int PIPE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_x1 = '0;
    logic [31:0] in_x2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_y;
    logic        out_nv;
    logic [4:0]  out_tag;

    fcmp_pipe #(.EXP_W(8), .MAN_W(23), .PIPE(PIPE), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_nv(out_nv), .out_tag(out_tag)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [37:0] exp_q[$];
    int          acc_q[$];
    bit          lc_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_acc = 0;
    bit          stalled_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    check("result", {26'd0, out_tag, out_nv, out_y}, {26'd0, exp_q[0]});
                    if (!stalled_prev && lc_q[0])
                        check("latency", 64'(cyc - acc_q[0]), 64'(PIPE));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        void'(lc_q.pop_front());
                    end
                end
            end
            stalled_prev = out_valid && !out_ready;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    // driver: offer one op, wait (bounded) for acceptance, record the expectation
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input logic [31:0] ey, input logic env,
                        input bit lc);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_x1    = a;
        in_x2    = b;
        in_tag   = tg;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_q.push_back({tg, env, ey});
            acc_q.push_back(cyc);
            lc_q.push_back(lc);
            n_acc++;
        end else begin
            check("accept_timeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom_range(0, 7));
        in_x1    = $urandom;
        in_x2    = $urandom;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        nv;
    } vec_t;

    vec_t vecs[21] = '{
        '{3'd2, 32'h00000000, 32'h80000000, 32'h1,        1'b0},
        '{3'd0, 32'h00000000, 32'h80000000, 32'h1,        1'b0},
        '{3'd1, 32'h00000000, 32'h80000000, 32'h0,        1'b0},
        '{3'd1, 32'hBF800000, 32'hC0000000, 32'h0,        1'b0},
        '{3'd2, 32'hC0000000, 32'hBF800000, 32'h1,        1'b0},
        '{3'd1, 32'h00000001, 32'h7F800000, 32'h1,        1'b0},
        '{3'd0, 32'h7FC00000, 32'h3F800000, 32'h0,        1'b0},
        '{3'd1, 32'h7FC00000, 32'h3F800000, 32'h0,        1'b1},
        '{3'd0, 32'h7F800001, 32'h3F800000, 32'h0,        1'b1},
        '{3'd3, 32'h7FC00000, 32'h40400000, 32'h40400000, 1'b0},
        '{3'd4, 32'h7FC00000, 32'hFFC00000, 32'h7FC00000, 1'b0},
        '{3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0},
        '{3'd4, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1},
        '{3'd4, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0},
        '{3'd3, 32'h3F800000, 32'hBF800000, 32'hBF800000, 1'b0},
        '{3'd4, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0},
        '{3'd5, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b0},
        '{3'd3, 32'h7F800001, 32'h7FC00000, 32'h7FC00000, 1'b1},
        '{3'd2, 32'hFF800000, 32'h80000001, 32'h1,        1'b0},
        '{3'd0, 32'h3F800000, 32'h3F800000, 32'h1,        1'b0},
        '{3'd4, 32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 1'b0}
    };

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_nv", 64'(out_nv), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // directed vectors, back-to-back, out_ready high
        foreach (vecs[i])
            send(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), vecs[i].y, vecs[i].nv, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // backpressure: four ops while the consumer stalls for five cycles
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int t = 1; t <= 4; t++)
                    send(3'd3, 32'h3F800000 + 32'(t), 32'h40000000, 5'(t),
                         32'h3F800000 + 32'(t), 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("bp_accepts", 64'(n_acc), 64'd2);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int t = 1; t <= 4; t++) begin
                    @(negedge clk);
                    check("bp_valid", 64'(out_valid), 64'd1);
                    check("bp_tag", 64'(out_tag), 64'(t));
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // reset with two ops in flight: neither may appear afterwards
        send(3'd0, 32'h3F800000, 32'h3F800000, 5'd20, 32'h1, 1'b0, 1'b0);
        send(3'd1, 32'h3F800000, 32'h40000000, 5'd21, 32'h1, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        lc_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        send(3'd4, 32'hC0000000, 32'hBF800000, 5'd9, 32'hBF800000, 1'b0, 1'b1);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
